// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_stage                                                     |
// | Description : Registered MEM/WB write-back stage for the LEGv8 pipeline.  |
// |               Captures MEM results, extracts/extends sub-doubleword loads, |
// |               selects ALU / load / link write data, suppresses XZR writes  |
// |               and drives the register-file write port plus an EX bypass.   |
// | Options     : define WB_RETIRE_CNT_EN to add the retire_cnt output.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_stage #(
  parameter int DATA_W  = 64,
  parameter int REG_AW  = 5,
  parameter int XZR_IDX = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              in_link,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_rd_data,
  input  logic [DATA_W-1:0] in_pc_plus4,
  output logic              reg_write,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  output logic [DATA_W-1:0] fwd_data
);

  // Number of address bits that select a byte lane inside one data word.
  localparam int LANE = $clog2(DATA_W / 8);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic              valid_q;
  logic              done_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic              link_q;
  logic [1:0]        ld_size_q;
  logic              ld_signed_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] pc4_q;

  logic [LANE-1:0]   lane_off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] field_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] ext_load;
  logic [DATA_W-1:0] sel_data;
  logic              live;

  // Pipeline register: reset > flush > stall > capture; done_q marks an entry already written.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      ld_size_q    <= 2'b00;
      ld_signed_q  <= 1'b0;
      rd_q         <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
    end else if (stall) begin
      done_q <= done_q | valid_q;
    end else begin
      valid_q      <= in_valid;
      done_q       <= 1'b0;
      reg_write_q  <= in_reg_write;
      mem_to_reg_q <= in_mem_to_reg;
      link_q       <= in_link;
      ld_size_q    <= in_ld_size;
      ld_signed_q  <= in_ld_signed;
      rd_q         <= in_rd_addr;
      alu_q        <= in_alu_result;
      rdata_q      <= in_rd_data;
      pc4_q        <= in_pc_plus4;
    end
  end

  // Load lane extraction: round the address down to the access size, shift, mask and extend.
  // A doubleword (or a word on a 32-bit datapath) always starts at lane 0.
  always_comb begin
    lane_off   = '0;
    field_mask = '1;
    sign_bit   = 1'b0;
    case (ld_size_q)
      SZ_BYTE: lane_off = alu_q[LANE-1:0];
      SZ_HALF: lane_off = alu_q[LANE-1:0] & ~LANE'(1);
      SZ_WORD: lane_off = alu_q[LANE-1:0] & ~LANE'(3);
      default: lane_off = '0;
    endcase
    shifted = rdata_q >> {lane_off, 3'b000};
    case (ld_size_q)
      SZ_BYTE: begin
        field_mask = DATA_W'(8'hFF);
        sign_bit   = shifted[7];
      end
      SZ_HALF: begin
        field_mask = DATA_W'(16'hFFFF);
        sign_bit   = shifted[15];
      end
      SZ_WORD: begin
        field_mask = DATA_W'(32'hFFFF_FFFF);
        sign_bit   = shifted[31];
      end
      default: begin
        field_mask = DATA_W'(32'hFFFF_FFFF) | (DATA_W == 32 ? '0 : ~DATA_W'(32'hFFFF_FFFF));
        sign_bit   = shifted[31];
      end
    endcase
    ext_load = (shifted & field_mask) | ((ld_signed_q && sign_bit) ? ~field_mask : '0);
  end

  // Write-data select: link beats load, load beats ALU.
  always_comb begin
    sel_data = alu_q;
    if (link_q)
      sel_data = pc4_q;
    else if (mem_to_reg_q)
      sel_data = ext_load;
  end

  assign live       = valid_q & reg_write_q & (rd_q != REG_AW'(XZR_IDX));
  assign reg_write  = live & ~done_q;
  assign fwd_valid  = live;
  assign wr_addr    = valid_q ? rd_q : '0;
  assign fwd_addr   = wr_addr;
  assign write_data = valid_q ? sel_data : '0;
  assign fwd_data   = write_data;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Count each entry once, on the edge where it leaves the stage without being flushed.
  always_ff @(posedge clk) begin
    if (reset)
      retire_q <= '0;
    else if (valid_q && !done_q && !flush)
      retire_q <= retire_q + 32'd1;
  end

  assign retire_cnt = retire_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_stage                                                  |
// | Description : Self-checking bench for wb_stage (DATA_W=64): vector table   |
// |               for single-entry behaviour plus stall/flush/reset sequences. |
// |               Retire-counter checks are built when WB_RETIRE_CNT_EN is set.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_link;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed;
  logic [4:0]  in_rd_addr;
  logic [63:0] in_alu_result, in_rd_data, in_pc_plus4;
  logic        reg_write, fwd_valid;
  logic [4:0]  wr_addr, fwd_addr;
  logic [63:0] write_data, fwd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage #(.DATA_W(64), .REG_AW(5), .XZR_IDX(31)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_link(in_link), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_rd_addr(in_rd_addr), .in_alu_result(in_alu_result), .in_rd_data(in_rd_data),
    .in_pc_plus4(in_pc_plus4), .reg_write(reg_write), .wr_addr(wr_addr),
    .write_data(write_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid, rw, m2r, link, sgn;
    logic [1:0]  size;
    logic [4:0]  rd;
    logic [63:0] alu, rdata, pc4;
    logic        exp_rw, exp_fv;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[12];
  localparam logic [63:0] RD = 64'h8877_6655_4433_2211;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic rw, input logic fv,
                            input logic [4:0] addr, input logic [63:0] data);
    check({name, ".reg_write"}, 64'(reg_write), 64'(rw));
    check({name, ".fwd_valid"}, 64'(fwd_valid), 64'(fv));
    check({name, ".wr_addr"}, 64'(wr_addr), 64'(addr));
    check({name, ".fwd_addr"}, 64'(fwd_addr), 64'(addr));
    check({name, ".write_data"}, write_data, data);
    check({name, ".fwd_data"}, fwd_data, data);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [63:0] alu);
    in_valid = v; in_reg_write = rw; in_rd_addr = rd; in_alu_result = alu;
    in_mem_to_reg = 1'b0; in_link = 1'b0; in_ld_size = 2'b11; in_ld_signed = 1'b0;
    in_rd_data = RD; in_pc_plus4 = 64'h0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int rw_cnt, fv_cnt;
    //            name      val rw m2r lnk sgn size  rd  alu              rdata pc4       erw efv eaddr edata
    vecs[0]  = '{"alu",     1, 1, 0, 0, 0, 2'b11, 3,  64'h1234,        RD, 64'h0,     1, 1, 3,  64'h1234};
    vecs[1]  = '{"ldurb_s7",1, 1, 1, 0, 1, 2'b00, 5,  64'h1007,        RD, 64'h0,     1, 1, 5,  64'hFFFF_FFFF_FFFF_FF88};
    vecs[2]  = '{"ldurh_u2",1, 1, 1, 0, 0, 2'b01, 6,  64'h2002,        RD, 64'h0,     1, 1, 6,  64'h4433};
    vecs[3]  = '{"ldursw4", 1, 1, 1, 0, 1, 2'b10, 7,  64'h3004,        RD, 64'h0,     1, 1, 7,  64'hFFFF_FFFF_8877_6655};
    vecs[4]  = '{"bl",      1, 1, 1, 1, 0, 2'b11, 30, 64'hDEAD,        RD, 64'h400,   1, 1, 30, 64'h400};
    vecs[5]  = '{"bl_xzr",  1, 1, 1, 1, 0, 2'b11, 31, 64'hDEAD,        RD, 64'h400,   0, 0, 31, 64'h400};
    vecs[6]  = '{"misal_w6",1, 1, 1, 0, 0, 2'b10, 8,  64'h4006,        RD, 64'h0,     1, 1, 8,  64'h8877_6655};
    vecs[7]  = '{"misal_h3",1, 1, 1, 0, 1, 2'b01, 9,  64'h4003,        RD, 64'h0,     1, 1, 9,  64'h4433};
    vecs[8]  = '{"ldur_d",  1, 1, 1, 0, 1, 2'b11, 10, 64'h5005,        RD, 64'h0,     1, 1, 10, RD};
    vecs[9]  = '{"invalid", 0, 1, 0, 0, 0, 2'b11, 11, 64'h9999,        RD, 64'h0,     0, 0, 0,  64'h0};
    vecs[10] = '{"no_write",1, 0, 0, 0, 0, 2'b11, 12, 64'h5555,        RD, 64'h0,     0, 0, 12, 64'h5555};
    vecs[11] = '{"ldurh_s6",1, 1, 1, 0, 1, 2'b01, 13, 64'h6006,        RD, 64'h0,     1, 1, 13, 64'hFFFF_FFFF_FFFF_8877};

    // Reset held two cycles with a live-looking input pattern.
    stall = 0; flush = 0; reset = 1;
    drive(1, 1, 5'd3, 64'hABCD);
    step(); step();
    check_outs("reset_held", 0, 0, 5'd0, 64'h0);
    drive(0, 0, 5'd0, 64'h0);
    reset = 0;
    step();
    check_outs("reset_rel", 0, 0, 5'd0, 64'h0);
`ifdef WB_RETIRE_CNT_EN
    check("retire_reset", 64'(retire_cnt), 64'd0);
`endif

    // Table-driven single-entry vectors.
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].valid; in_reg_write = vecs[i].rw; in_mem_to_reg = vecs[i].m2r;
      in_link = vecs[i].link; in_ld_signed = vecs[i].sgn; in_ld_size = vecs[i].size;
      in_rd_addr = vecs[i].rd; in_alu_result = vecs[i].alu; in_rd_data = vecs[i].rdata;
      in_pc_plus4 = vecs[i].pc4;
      step();
      check_outs(vecs[i].name, vecs[i].exp_rw, vecs[i].exp_fv, vecs[i].exp_addr, vecs[i].exp_data);
    end

    // Stall for 3 cycles: one write pulse, bypass held for 4 cycles, data held.
    drive(1, 1, 5'd7, 64'h77);
    rw_cnt = 0; fv_cnt = 0;
    step();
    rw_cnt += int'(reg_write); fv_cnt += int'(fwd_valid);
    stall = 1;
    drive(1, 1, 5'd9, 64'hBAD);
    for (int k = 0; k < 3; k++) begin
      step();
      rw_cnt += int'(reg_write); fv_cnt += int'(fwd_valid);
      check("stall_hold_data", write_data, 64'h77);
    end
    check("stall_rw_pulses", 64'(rw_cnt), 64'd1);
    check("stall_fv_cycles", 64'(fv_cnt), 64'd4);
    stall = 0;
    drive(0, 0, 5'd0, 64'h0);
    step();
    check_outs("stall_drain", 0, 0, 5'd0, 64'h0);

    // Flush together with stall on the second stalled cycle drops the entry.
    drive(1, 1, 5'd4, 64'h44);
    step();
    stall = 1;
    step();
    check_outs("fl_stall1", 0, 1, 5'd4, 64'h44);
    flush = 1;
    step();
    check_outs("fl_dropped", 0, 0, 5'd0, 64'h0);
    flush = 0; stall = 0;
    drive(0, 0, 5'd0, 64'h0);

    // Reset mid-stall drops the entry without a further write.
    drive(1, 1, 5'd2, 64'h22);
    step();
    stall = 1;
    step();
    reset = 1;
    step();
    check_outs("rst_midstall", 0, 0, 5'd0, 64'h0);
    reset = 0; stall = 0;
    drive(0, 0, 5'd0, 64'h0);
    step();
    check_outs("rst_after", 0, 0, 5'd0, 64'h0);

`ifdef WB_RETIRE_CNT_EN
    // Five entries (one XZR), one of them flushed while stalled: four retire.
    check("retire_start", 64'(retire_cnt), 64'd0);
    drive(1, 1, 5'd1, 64'h1);  step();
    drive(1, 1, 5'd31, 64'h2); step();
    drive(1, 1, 5'd3, 64'h3);  step();
    drive(1, 1, 5'd4, 64'h4);  step();
    stall = 1; flush = 1;
    step();
    stall = 0; flush = 0;
    drive(1, 1, 5'd5, 64'h5);  step();
    drive(0, 0, 5'd0, 64'h0);  step();
    check("retire_four", 64'(retire_cnt), 64'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
